// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered RISC-V immediate extender behind a 2-entry valid/ready elastic buffer
module imm_ext_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     inm,
  input  logic [2:0]      src,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] inmExt,
  output logic            out_illegal
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nxt;
  logic [XLEN:0] mem [2];
  logic wp, rp, push, pop, ill;
  logic [31:0] imm;
  logic [XLEN-1:0] ext;
  always_comb begin
    imm = src == 3'b000 ? {{20{inm[24]}}, inm[24:13]} :
          src == 3'b001 ? {{20{inm[24]}}, inm[24:18], inm[4:0]} :
          src == 3'b010 ? {{20{inm[24]}}, inm[0], inm[23:18], inm[4:1], 1'b0} :
          src == 3'b011 ? {inm[24:5], 12'b0} :
          src == 3'b100 ? {{12{inm[24]}}, inm[12:5], inm[13], inm[23:14], 1'b0} :
          src == 3'b101 ? {27'b0, inm[12:8]} : '0;
    ill = src[2] & src[1];
  end
  // every 32-bit form is already sign-correct at bit 31 (Z and illegal have it clear)
  assign ext = XLEN'($signed(imm));
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;
  always_comb begin
    state_nxt = flush ? EMPTY :
                (push && !pop) ? (state == EMPTY ? ONE : FULL) :
                (pop && !push) ? (state == FULL ? ONE : EMPTY) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      wp <= 1'b0;
      rp <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        wp <= 1'b0;
        rp <= 1'b0;
      end else begin
        if (push) begin
          mem[wp] <= {ext, ill};
          wp <= ~wp;
        end
        if (pop) rp <= ~rp;
      end
    end
  end
  assign {inmExt, out_illegal} = out_valid ? mem[rp] : '0;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed checks of imm_ext_pipe at XLEN 32 and 64 driven in lockstep
module tb_imm_ext_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [24:0] inm = '0;
  logic [2:0] src = '0;
  logic r32, v32, il32, r64, v64, il64;
  logic [31:0] x32;
  logic [63:0] x64;
  int checks = 0;
  int failures = 0;
  logic [24:0] vin [7];
  logic [2:0]  vs  [7];
  logic [63:0] ve  [7];

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32),
    .inm(inm), .src(src), .flush(flush), .out_valid(v32), .out_ready(out_ready), .inmExt(x32),
    .out_illegal(il32));
  imm_ext_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64),
    .inm(inm), .src(src), .flush(flush), .out_valid(v64), .out_ready(out_ready), .inmExt(x64),
    .out_illegal(il64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v);
    in_valid = v;
    inm = vin[k];
    src = vs[k];
  endtask

  task automatic head(input string tag, input int k);
    chk({tag, "_valid"}, {63'b0, v32}, 64'd1);
    chk({tag, "_x32"}, {32'b0, x32}, {32'b0, ve[k][31:0]});
    chk({tag, "_x64"}, x64, ve[k]);
    chk({tag, "_ill"}, {62'b0, il32, il64}, 64'd0);
  endtask

  task automatic empty(input string tag);
    chk({tag, "_valid"}, {62'b0, v32, v64}, 64'd0);
    chk({tag, "_ready"}, {62'b0, r32, r64}, 64'd3);
    chk({tag, "_x"}, x64 | {32'b0, x32}, 64'd0);
    chk({tag, "_ill"}, {62'b0, il32, il64}, 64'd0);
  endtask

  initial begin
    vin[0] = 25'b1001110011110000000000000; vs[0] = 3'b000; ve[0] = 64'hFFFFFFFFFFFFF9CF;
    vin[1] = 25'b1101010000000000000010101; vs[1] = 3'b001; ve[1] = 64'hFFFFFFFFFFFFFD55;
    vin[2] = 25'h0000008;                   vs[2] = 3'b010; ve[2] = 64'h0000000000000008;
    vin[3] = 25'h0000020;                   vs[3] = 3'b011; ve[3] = 64'h0000000000001000;
    vin[4] = 25'h1FFFFFF;                   vs[4] = 3'b100; ve[4] = 64'hFFFFFFFFFFFFFFFE;
    vin[5] = 25'h0001F00;                   vs[5] = 3'b101; ve[5] = 64'h000000000000001F;
    vin[6] = 25'h1000000;                   vs[6] = 3'b011; ve[6] = 64'hFFFFFFFF80000000;

    #3 empty("reset");
    #9 rst_n = 1'b1;
    cyc();
    empty("post_reset");

    drive(0, 1'b1);
    cyc();
    in_valid = 1'b0;
    head("first_I", 0);
    chk("first_ready", {63'b0, r32}, 64'd1);
    out_ready = 1'b1;
    cyc();
    empty("first_pop");

    for (int k = 1; k < 7; k++) begin
      drive(k, 1'b1);
      cyc();
      head($sformatf("stream%0d", k), k);
    end
    in_valid = 1'b0;
    cyc();
    empty("stream_drain");

    out_ready = 1'b0;
    drive(0, 1'b1);
    cyc();
    head("bp_one", 0);
    chk("bp_one_ready", {63'b0, r32}, 64'd1);
    drive(1, 1'b1);
    cyc();
    head("bp_full", 0);
    chk("bp_full_ready", {62'b0, r32, r64}, 64'd0);
    drive(4, 1'b1);
    cyc();
    head("bp_hold", 0);
    chk("bp_hold_ready", {63'b0, r32}, 64'd0);
    out_ready = 1'b1;
    cyc();
    head("bp_pop_S", 1);
    chk("bp_pop_ready", {63'b0, r32}, 64'd1);
    cyc();
    in_valid = 1'b0;
    head("bp_pop_J", 4);
    cyc();
    empty("bp_drain");

    in_valid = 1'b1;
    src = 3'b110;
    inm = 25'h1FFFFFF;
    cyc();
    chk("ill6_valid", {63'b0, v32}, 64'd1);
    chk("ill6_flag", {62'b0, il32, il64}, 64'd3);
    chk("ill6_x", x64 | {32'b0, x32}, 64'd0);
    src = 3'b111;
    inm = 25'h0ABCDEF;
    cyc();
    chk("ill7_flag", {62'b0, il32, il64}, 64'd3);
    chk("ill7_x", x64 | {32'b0, x32}, 64'd0);
    drive(0, 1'b1);
    cyc();
    head("ill_then_legal", 0);
    in_valid = 1'b0;
    cyc();
    empty("ill_drain");

    out_ready = 1'b0;
    drive(0, 1'b1);
    cyc();
    drive(1, 1'b1);
    cyc();
    chk("fl_full_ready", {63'b0, r32}, 64'd0);
    drive(4, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    empty("flush");
    cyc();
    empty("flush_stays");
    drive(6, 1'b1);
    cyc();
    in_valid = 1'b0;
    head("post_flush_push", 6);
    cyc();
    empty("post_flush_drain");

    out_ready = 1'b0;
    drive(2, 1'b1);
    cyc();
    in_valid = 1'b0;
    head("pre_areset", 2);
    #2 rst_n = 1'b0;
    #1 empty("areset_mid");
    #2 chk("areset_hold", {63'b0, v32}, 64'd0);
    #1 rst_n = 1'b1;
    drive(0, 1'b1);
    cyc();
    in_valid = 1'b0;
    head("after_areset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Registered, handshaked immediate extender for the decode stage of the RISC-V core. It takes instruction bits [31:7] plus an immediate-format select and produces the XLEN-wide extended immediate. It covers all base formats (I, S, B, U, J, CSR zero-extend) and flags illegal selects. A 2-entry elastic buffer with valid/ready on both sides decouples fetch/decode from execute stalls, and a synchronous flush supports branch redirects.

## Interface
- XLEN, 32, output width; legal values 32 or 64
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept; depends on state only (no combinational path from out_ready)
- inm  in  25  instruction bits [31:7]; inm[k] = instr[k+7]
- src  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR uimm), 110/111 illegal
- flush  in  1  synchronous clear of all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- inmExt  out  XLEN  extended immediate of head entry
- out_illegal  out  1  head entry had illegal src

## Operation
- Extension is computed combinationally on input and stored per entry as {inmExt, illegal}.
- I: sext(inm[24:13])
- S: sext({inm[24:18], inm[4:0]})
- B: sext({inm[24], inm[0], inm[23:18], inm[4:1], 1'b0})
- U: sext({inm[24:5], 12'b0}); with XLEN=64, bits 63:32 copy inm[24]
- J: sext({inm[24], inm[12:5], inm[13], inm[23:14], 1'b0})
- Z: zext(inm[12:8])
- 110/111: inmExt = 0, illegal = 1
- sext/zext always extend to XLEN.
- Buffer: 2-entry FIFO with count register (0..2), read/write pointers, strict in-order delivery.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != 2); out_valid = (count != 0).
- inmExt/out_illegal are driven from the head entry. They are 0 when count = 0.
- Push and pop in the same cycle with count = 1 leaves count at 1; the new entry becomes head next cycle.
- Push is impossible at count = 2, even if out_ready = 1 that cycle. This is the intended registered-ready behaviour.
- Flush: next cycle count = 0, and pointers reset to 0. A same-cycle push and pop are discarded, and pop has no effect. Flush dominates all other events.
- State machine is implied by count: EMPTY (0), ONE (1), FULL (2).
  - EMPTY moves to ONE on push.
  - ONE moves to FULL on push without pop, and to EMPTY on pop without push.
  - FULL moves to ONE on pop.
  - flush moves any state to EMPTY.

## Timing
- Reset (rst_n low, asynchronous): count = 0, pointers = 0, storage cleared.
- Reset output values: out_valid = 0, inmExt = 0, out_illegal = 0, in_ready = 1.
- Reset deassertion takes effect at the first clk edge after release. No output glitches to nonzero during reset.
- Latency: an entry pushed at edge N is visible on out_valid/inmExt after edge N; 1 cycle when empty.
- Throughput: 1 entry/cycle sustained while out_ready = 1.
- Outputs are stable while out_valid = 1 and out_ready = 0.
- Reset asserted mid-transfer drops all entries. No partial state survives.

## Test plan
- Reset, then push inm = 25'b1001110011110000000000000 with src = 000 (I), XLEN = 32 -> next cycle out_valid = 1, inmExt = 32'hFFFFF9CF. Same push with XLEN = 64 -> 64'hFFFFFFFFFFFFF9CF.
- Back-to-back pushes with out_ready = 1:
  - S, inm = 25'b1101010000000000000010101 -> 32'hFFFFFD55
  - B, inm = 25'h0000008 -> 32'h00000008
  - U, inm = 25'h0000020 -> 32'h00001000
  - J, inm = 25'h1FFFFFF -> 32'hFFFFFFFE
  - Z, inm = 25'h0001F00 -> 32'h0000001F
  - Expect one result per cycle, in order.
- Backpressure: out_ready = 0, present 3 pushes (I, S, J values above).
  - Two are accepted; in_ready = 0 after the second. The third is held.
  - Raise out_ready: I result stays stable until popped; S and J follow; count returns to 0.
- Illegal: src = 110, any inm -> out_illegal = 1, inmExt = 0. A following legal entry has out_illegal = 0.
- Flush with count = 2 and a simultaneous push -> next cycle out_valid = 0, in_ready = 1. The flushed and same-cycle values never appear on the output.
- Assert rst_n low asynchronously between edges while count = 1 -> out_valid and inmExt drop to 0 immediately. After release the first new push behaves as in scenario 1.
